ibex_rf_bist: RTL and testbench

Built-in self-test engine for the flip-flop register file, acting as initiator on the register file's write port and both read ports. On a start request it writes an address-dependent pattern to every writable register, reads all registers back two per cycle, and compares them, then repeats with the inverted pattern. It sits between the ID stage and the register file. Top-level muxing hands it the register file ports while `busy_o` is high. It reports pass/fail plus the first failing address and phase.

---
 rtl/ibex_rf_bist.sv | 193 +++++++++++++++++++
 tb/tb_ibex_rf_bist.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_bist.sv
// ibex_rf_bist: self-test engine for the flip-flop register file (write/read-back/compare).
// Define RF_BIST_INV_PHASE_EN to add the second pass with the inverted pattern (WR1/RD1).
module ibex_rf_bist #(
    parameter int unsigned          NumWords    = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [31:0]          PatSeed     = 32'hA5A5_A5A5,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [4:0]           fail_addr_o,
    output logic                 fail_phase_o,
    output logic [4:0]           waddr_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 we_o,
    output logic [4:0]           raddr_a_o,
    output logic [4:0]           raddr_b_o,
    input  logic [DataWidth-1:0] rdata_a_i,
    input  logic [DataWidth-1:0] rdata_b_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR0,
        S_RD0,
`ifdef RF_BIST_INV_PHASE_EN
        S_WR1,
        S_RD1,
`endif
        S_DONE
    } state_e;

    localparam logic [4:0] LastWr = 5'(NumWords - 2);
    localparam logic [4:0] LastRd = 5'(NumWords / 2 - 1);

    state_e         r_state;
    logic [4:0]     r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_pass;
    logic [4:0]     r_fail_addr;
`ifdef RF_BIST_INV_PHASE_EN
    logic           r_fail_phase;
`endif

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_ph;
    logic [4:0]           w_waddr;
    logic [4:0]           w_raddr_a;
    logic [4:0]           w_raddr_b;
    logic [DataWidth-1:0] w_exp_a;
    logic [DataWidth-1:0] w_exp_b;
    logic                 w_miss_a;
    logic                 w_miss_b;

    function automatic logic [DataWidth-1:0] pat(input logic [4:0] a, input logic ph);
        return DataWidth'(PatSeed) ^ DataWidth'(a) ^ {DataWidth{ph}};
    endfunction

    always_comb begin
        w_wr = 1'b0;
        w_rd = 1'b0;
        w_ph = 1'b0;
        case (r_state)
            S_WR0: w_wr = 1'b1;
            S_RD0: w_rd = 1'b1;
`ifdef RF_BIST_INV_PHASE_EN
            S_WR1: begin
                w_wr = 1'b1;
                w_ph = 1'b1;
            end
            S_RD1: begin
                w_rd = 1'b1;
                w_ph = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Counter runs from 0; register 0 is skipped by offsetting the write address.
    assign w_waddr   = r_cnt + 5'd1;
    assign w_raddr_a = {r_cnt[3:0], 1'b0};
    assign w_raddr_b = {r_cnt[3:0], 1'b1};

    assign w_exp_a  = (w_raddr_a == 5'd0) ? WordZeroVal : pat(w_raddr_a, w_ph);
    assign w_exp_b  = pat(w_raddr_b, w_ph);
    assign w_miss_a = w_rd && (rdata_a_i != w_exp_a);
    assign w_miss_b = w_rd && (rdata_b_i != w_exp_b);

    assign we_o      = w_wr;
    assign waddr_o   = w_wr ? w_waddr : '0;
    assign wdata_o   = w_wr ? pat(w_waddr, w_ph) : '0;
    assign raddr_a_o = w_rd ? w_raddr_a : '0;
    assign raddr_b_o = w_rd ? w_raddr_b : '0;

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign pass_o       = r_pass;
    assign fail_addr_o  = r_fail_addr;
`ifdef RF_BIST_INV_PHASE_EN
    assign fail_phase_o = r_fail_phase;
`else
    assign fail_phase_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
`ifdef RF_BIST_INV_PHASE_EN
            r_fail_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_state     <= S_WR0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_addr <= '0;
`ifdef RF_BIST_INV_PHASE_EN
                        r_fail_phase <= 1'b0;
`endif
                    end
                end
                S_WR0: begin
                    if (r_cnt == LastWr) begin
                        r_cnt   <= '0;
                        r_state <= S_RD0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
`ifdef RF_BIST_INV_PHASE_EN
                S_WR1: begin
                    if (r_cnt == LastWr) begin
                        r_cnt   <= '0;
                        r_state <= S_RD1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_RD0, S_RD1: begin
`else
                S_RD0: begin
`endif
                    if (w_miss_a || w_miss_b) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_fail_addr <= w_miss_a ? w_raddr_a : w_raddr_b;
`ifdef RF_BIST_INV_PHASE_EN
                        r_fail_phase <= w_ph;
`endif
                    end else if (r_cnt == LastRd) begin
                        r_cnt <= '0;
`ifdef RF_BIST_INV_PHASE_EN
                        if (!w_ph) begin
                            r_state <= S_WR1;
                        end else begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end
`else
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rf_bist.sv
// Directed bench for ibex_rf_bist: ideal/faulty register file models at 32 and 16 words.
module tb_ibex_rf_bist;

`ifdef RF_BIST_INV_PHASE_EN
    localparam int RUN32 = 94, WE32 = 62, RUN16 = 46, WE16 = 30;
    localparam int STUCK_RUN = 82, STUCK_PASS = 0, STUCK_ADDR = 7, STUCK_PH = 1;
`else
    localparam int RUN32 = 47, WE32 = 31, RUN16 = 23, WE16 = 15;
    localparam int STUCK_RUN = 47, STUCK_PASS = 1, STUCK_ADDR = 0, STUCK_PH = 0;
`endif

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, start16 = 1'b0;
    logic        busy32, done32, pass32, fph32, we32;
    logic        busy16, done16, pass16, fph16, we16;
    logic [4:0]  faddr32, waddr32, ra32, rb32;
    logic [4:0]  faddr16, waddr16, ra16, rb16;
    logic [31:0] wdata32, rda32, rdb32, wdata16, rda16, rdb16;

    logic flt_r0 = 1'b0;
    logic flt_s7 = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    logic [4:0]  s_waddr0, s_waddr30, s_waddr31, s_ra31, s_rb31, s_waddr47;
    logic [31:0] s_wdata0, s_wdata30, s_wdata47;
    logic        s_we0, s_we31;

    ibex_rf_bist u_dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start32),
        .busy_o(busy32), .done_o(done32), .pass_o(pass32),
        .fail_addr_o(faddr32), .fail_phase_o(fph32),
        .waddr_o(waddr32), .wdata_o(wdata32), .we_o(we32),
        .raddr_a_o(ra32), .raddr_b_o(rb32),
        .rdata_a_i(rda32), .rdata_b_i(rdb32)
    );

    ibex_rf_bist #(.NumWords(16)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start16),
        .busy_o(busy16), .done_o(done16), .pass_o(pass16),
        .fail_addr_o(faddr16), .fail_phase_o(fph16),
        .waddr_o(waddr16), .wdata_o(wdata16), .we_o(we16),
        .raddr_a_o(ra16), .raddr_b_o(rb16),
        .rdata_a_i(rda16), .rdata_b_i(rdb16)
    );

    // Register file models: register 0 hardwired (optionally faulty), reg 7 bit 3 optionally stuck at 0.
    logic [31:0] rf32 [32];
    logic [31:0] rf16 [16];

    always @(posedge clk) begin
        if (we32) rf32[waddr32] <= wdata32;
        if (we16) rf16[waddr16[3:0]] <= wdata16;
    end

    always_comb begin
        rda32 = (ra32 == 5'd0) ? {31'd0, flt_r0} : rf32[ra32];
        rdb32 = (rb32 == 5'd0) ? {31'd0, flt_r0} : rf32[rb32];
        if (flt_s7 && ra32 == 5'd7) rda32[3] = 1'b0;
        if (flt_s7 && rb32 == 5'd7) rdb32[3] = 1'b0;
        rda16 = (ra16 == 5'd0) ? 32'd0 : rf16[ra16[3:0]];
        rdb16 = (rb16 == 5'd0) ? 32'd0 : rf16[rb16[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start, then counts busy and we cycles until done (sampled on falling edges).
    task automatic run(input bit sel, input int pulse_at, output int nbusy, output int nwe);
        bit seen;
        nbusy = 0;
        nwe   = 0;
        seen  = 1'b0;
        @(negedge clk);
        if (sel) start16 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        start32 = 1'b0;
        chk("start_busy", sel ? busy16 : busy32, 1);
        chk("start_done_clr", sel ? done16 : done32, 0);
        for (int c = 0; c < 400; c++) begin
            if (sel ? done16 : done32) begin
                seen = 1'b1;
                break;
            end
            if (sel) start16 = (c == pulse_at); else start32 = (c == pulse_at);
            if (sel ? busy16 : busy32) nbusy++;
            if (sel ? we16 : we32) nwe++;
            if (!sel && c == 0)  begin s_waddr0 = waddr32; s_wdata0 = wdata32; s_we0 = we32; end
            if (!sel && c == 30) begin s_waddr30 = waddr32; s_wdata30 = wdata32; end
            if (!sel && c == 31) begin s_waddr31 = waddr32; s_ra31 = ra32; s_rb31 = rb32; s_we31 = we32; end
            if (!sel && c == 47) begin s_waddr47 = waddr32; s_wdata47 = wdata32; end
            @(negedge clk);
        end
        start16 = 1'b0;
        start32 = 1'b0;
        chk("run_finished", {31'd0, seen}, 1);
    endtask

    int nb, nw;

    initial begin
        #12;
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_pass", pass32, 0);
        chk("rst_we", we32, 0);
        chk("rst_fail_addr", faddr32, 0);
        chk("rst_fail_phase", fph32, 0);
        chk("rst_waddr", waddr32, 0);
        chk("rst_wdata", wdata32, 0);
        chk("rst_raddr", {ra32, rb32}, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        run(1'b0, -1, nb, nw);
        chk("ideal_busy_cycles", nb, RUN32);
        chk("ideal_we_cycles", nw, WE32);
        chk("ideal_done", done32, 1);
        chk("ideal_busy_low", busy32, 0);
        chk("ideal_pass", pass32, 1);
        chk("first_waddr", s_waddr0, 1);
        chk("first_wdata", s_wdata0, 32'hA5A5_A5A4);
        chk("first_we", s_we0, 1);
        chk("last_waddr", s_waddr30, 31);
        chk("last_wdata", s_wdata30, 32'hA5A5_A5BA);
        chk("rd0_we", s_we31, 0);
        chk("rd0_waddr", s_waddr31, 0);
        chk("rd0_raddr_a", s_ra31, 0);
        chk("rd0_raddr_b", s_rb31, 1);
`ifdef RF_BIST_INV_PHASE_EN
        chk("wr1_waddr", s_waddr47, 1);
        chk("wr1_wdata", s_wdata47, 32'h5A5A_5A5B);
`endif

        run(1'b0, 5, nb, nw);
        chk("midrun_start_cycles", nb, RUN32);
        chk("midrun_start_pass", pass32, 1);

        flt_s7 = 1'b1;
        run(1'b0, -1, nb, nw);
        flt_s7 = 1'b0;
        chk("stuck_cycles", nb, STUCK_RUN);
        chk("stuck_done", done32, 1);
        chk("stuck_pass", pass32, STUCK_PASS);
        chk("stuck_fail_addr", faddr32, STUCK_ADDR);
        chk("stuck_fail_phase", fph32, STUCK_PH);

        flt_r0 = 1'b1;
        run(1'b0, -1, nb, nw);
        flt_r0 = 1'b0;
        chk("r0_cycles", nb, 32);
        chk("r0_done", done32, 1);
        chk("r0_pass", pass32, 0);
        chk("r0_fail_addr", faddr32, 0);
        chk("r0_fail_phase", fph32, 0);

        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_we", we32, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_we", we32, 0);
        chk("async_rst_busy", busy32, 0);
        chk("async_rst_done", done32, 0);
        chk("async_rst_pass", pass32, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_busy", busy32, 0);
        chk("idle_after_rst_done", done32, 0);
        chk("idle_after_rst_we", we32, 0);

        run(1'b1, -1, nb, nw);
        chk("n16_cycles", nb, RUN16);
        chk("n16_we_cycles", nw, WE16);
        chk("n16_done", done16, 1);
        chk("n16_pass", pass16, 1);
        chk("n16_fail_phase", fph16, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
